// File: rtl/alu_pkg.sv
// Shared definitions for the ALU/UART sequencer: default widths, FSM encoding, opcodes.
// SEND_HI is only part of the encoding when ALU_CARRY_BYTE_EN is defined.
package alu_pkg;

    localparam int DEF_NB_BITS = 8;
    localparam int DEF_NB_OPE  = 6;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        EXEC,
`ifdef ALU_CARRY_BYTE_EN
        SEND_LO,
        SEND_HI
`else
        SEND_LO
`endif
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRL = 6'b000010;
    localparam logic [5:0] OP_SRA = 6'b000011;

endpackage

// File: rtl/alu_uart_ctrl.sv
// Collects A, B and opcode bytes from the UART, holds them on the ALU, and returns the result.
// Define ALU_CARRY_BYTE_EN to also send the carry/borrow bit as a second byte.
module alu_uart_ctrl
    import alu_pkg::*;
#(
    parameter int NB_BITS = DEF_NB_BITS,
    parameter int NB_OPE  = DEF_NB_OPE
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic [NB_BITS-1:0] o_dato_a,
    output logic [NB_BITS-1:0] o_dato_b,
    output logic [NB_OPE-1:0]  o_ope_sel,
    input  logic [NB_BITS:0]   i_alu_result,
    output logic               o_busy
);

    state_t             state_q, state_d;
    logic [NB_BITS:0]   result_q, result_d;
    logic [NB_BITS-1:0] dato_a_d, dato_b_d;
    logic [NB_OPE-1:0]  ope_sel_d;
    logic [7:0]         tx_data_d;
    logic               tx_start_d;
    logic               busy_d;
    logic               tx_done_ok;

    // A done pulse coinciding with our own start pulse cannot belong to this byte.
    assign tx_done_ok = i_tx_done && !o_tx_start;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q    <= WAIT_A;
            result_q   <= '0;
            o_dato_a   <= '0;
            o_dato_b   <= '0;
            o_ope_sel  <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            o_dato_a   <= dato_a_d;
            o_dato_b   <= dato_b_d;
            o_ope_sel  <= ope_sel_d;
            o_tx_data  <= tx_data_d;
            o_tx_start <= tx_start_d;
            o_busy     <= busy_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        dato_a_d   = o_dato_a;
        dato_b_d   = o_dato_b;
        ope_sel_d  = o_ope_sel;
        tx_data_d  = o_tx_data;
        tx_start_d = 1'b0;

        case (state_q)
            WAIT_A: begin
                if (i_rx_valid) begin
                    dato_a_d = i_rx_data[NB_BITS-1:0];
                    state_d  = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_valid) begin
                    dato_b_d = i_rx_data[NB_BITS-1:0];
                    state_d  = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (i_rx_valid) begin
                    ope_sel_d = i_rx_data[NB_OPE-1:0];
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                // Load the low byte together with the start pulse so both are registered on entry.
                result_d   = i_alu_result;
                tx_data_d  = 8'(i_alu_result[NB_BITS-1:0]);
                tx_start_d = 1'b1;
                state_d    = SEND_LO;
            end
            SEND_LO: begin
                if (tx_done_ok) begin
`ifdef ALU_CARRY_BYTE_EN
                    tx_data_d  = {7'b0, result_q[NB_BITS]};
                    tx_start_d = 1'b1;
                    state_d    = SEND_HI;
`else
                    state_d    = WAIT_A;
`endif
                end
            end
`ifdef ALU_CARRY_BYTE_EN
            SEND_HI: begin
                if (tx_done_ok) begin
                    state_d = WAIT_A;
                end
            end
`endif
            default: state_d = WAIT_A;
        endcase

        busy_d = (state_d != WAIT_A);
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed-vector bench for alu_uart_ctrl with a queue scoreboard on the transmit side.
module tb_alu_uart_ctrl;
    import alu_pkg::*;

    localparam int NB_BITS = 8;
    localparam int NB_OPE  = 6;
`ifdef ALU_CARRY_BYTE_EN
    localparam int N_TX = 2;
`else
    localparam int N_TX = 1;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         rx_data = '0;
    logic               rx_valid = 1'b0;
    logic [7:0]         tx_data;
    logic               tx_start;
    logic               tx_done = 1'b0;
    logic [NB_BITS-1:0] dato_a, dato_b;
    logic [NB_OPE-1:0]  ope_sel;
    logic [NB_BITS:0]   alu_result;
    logic               busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];
    logic       prev_start = 1'b0;

    always #5 clk = ~clk;

    alu_uart_ctrl #(.NB_BITS(NB_BITS), .NB_OPE(NB_OPE)) dut (
        .i_clock      (clk),
        .i_reset_n    (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_tx_data    (tx_data),
        .o_tx_start   (tx_start),
        .i_tx_done    (tx_done),
        .o_dato_a     (dato_a),
        .o_dato_b     (dato_b),
        .o_ope_sel    (ope_sel),
        .i_alu_result (alu_result),
        .o_busy       (busy)
    );

    // Stand-in combinational ALU driven by the sequencer outputs.
    always_comb begin
        case (ope_sel)
            OP_ADD:  alu_result = {1'b0, dato_a} + {1'b0, dato_b};
            OP_SUB:  alu_result = {1'b0, dato_a} - {1'b0, dato_b};
            OP_AND:  alu_result = {1'b0, dato_a & dato_b};
            OP_OR:   alu_result = {1'b0, dato_a | dato_b};
            OP_XOR:  alu_result = {1'b0, dato_a ^ dato_b};
            OP_NOR:  alu_result = {1'b0, ~(dato_a | dato_b)};
            default: alu_result = '0;
        endcase
    end

    // Monitor: every start pulse must carry the next expected byte and last one cycle.
    always @(negedge clk) begin
        if (rst_n && tx_start) begin
            checks++;
            if (prev_start) begin
                errors++;
                $display("FAIL tx_start_width: high on consecutive cycles, required single-cycle pulse");
            end else if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got 0x%02h, required no transmission", tx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_data !== e) begin
                    errors++;
                    $display("FAIL tx_byte: got 0x%02h, required 0x%02h", tx_data, e);
                end
            end
        end
        prev_start = tx_start;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic wait_start();
        int i;
        for (i = 0; i < 50; i++) begin
            if (tx_start === 1'b1) break;
            @(negedge clk);
        end
        if (i == 50) begin
            checks++;
            errors++;
            $display("FAIL tx_timeout: got no tx_start in 50 cycles, required a start pulse");
        end
    endtask

    // Serve every byte of one result; optionally raise an illegal done with the start
    // pulse, and optionally inject a received byte on the final done edge.
    task automatic run_tx(input bit illegal_done, input bit collide, input logic [7:0] cbyte);
        for (int k = 0; k < N_TX; k++) begin
            wait_start();
            if (illegal_done && k == 0) tx_done = 1'b1;
            @(negedge clk);
            tx_done = 1'b0;
            @(negedge clk);
            if (collide && k == N_TX - 1) begin
                rx_data  = cbyte;
                rx_valid = 1'b1;
            end
            tx_done = 1'b1;
            @(negedge clk);
            tx_done  = 1'b0;
            rx_valid = 1'b0;
        end
    endtask

    task automatic push_exp(input logic [7:0] lo, input logic [7:0] hi);
        exp_q.push_back(lo);
        if (N_TX == 2) exp_q.push_back(hi);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 16'(busy), 16'h0);
        check("reset_tx_start", 16'(tx_start), 16'h0);
        check("reset_dato_a", 16'(dato_a), 16'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ADD 5 + 3, with an illegal done overlapping the start pulse
        push_exp(8'h08, 8'h00);
        send_byte(8'h05);
        check("add_dato_a", 16'(dato_a), 16'h05);
        check("add_busy_mid", 16'(busy), 16'h1);
        send_byte(8'h03);
        check("add_dato_b", 16'(dato_b), 16'h03);
        send_byte(8'h20);
        check("add_ope_sel", 16'(ope_sel), 16'h20);
        run_tx(1'b1, 1'b0, 8'h00);
        check("add_busy_end", 16'(busy), 16'h0);

        // SUB 3 - 5 borrows
        push_exp(8'hFE, 8'h01);
        send_byte(8'h03);
        send_byte(8'h05);
        send_byte(8'h22);
        run_tx(1'b0, 1'b0, 8'h00);
        check("sub_busy_end", 16'(busy), 16'h0);

        // opcode upper bits discarded: 0xE4 -> AND
        push_exp(8'h00, 8'h00);
        send_byte(8'hF0);
        send_byte(8'h0F);
        send_byte(8'hE4);
        check("mask_ope_sel", 16'(ope_sel), 16'h24);
        run_tx(1'b0, 1'b0, 8'h00);

        // byte arriving during SEND_LO is dropped
        push_exp(8'h02, 8'h00);
        send_byte(8'h01);
        send_byte(8'h01);
        send_byte(8'h20);
        wait_start();
        send_byte(8'hAA);
        check("drop_dato_a", 16'(dato_a), 16'h01);
        check("drop_busy", 16'(busy), 16'h1);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        if (N_TX == 2) run_tx(1'b0, 1'b0, 8'h00);
        check("drop_busy_end", 16'(busy), 16'h0);

        // reset after two operand bytes
        send_byte(8'h10);
        send_byte(8'h20);
        rst_n = 1'b0;
        #1;
        check("rst_dato_a", 16'(dato_a), 16'h0);
        check("rst_dato_b", 16'(dato_b), 16'h0);
        check("rst_ope_sel", 16'(ope_sel), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_tx_data", 16'(tx_data), 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(8'h05, 8'h00);
        send_byte(8'h07);
        check("fresh_dato_a", 16'(dato_a), 16'h07);
        check("fresh_busy", 16'(busy), 16'h1);
        send_byte(8'h02);
        send_byte(8'h22);
        run_tx(1'b0, 1'b1, 8'h55);
        // rx byte on the final done edge must be dropped
        check("collide_busy", 16'(busy), 16'h0);
        check("collide_dato_a", 16'(dato_a), 16'h07);
        check("collide_tx_start", 16'(tx_start), 16'h0);

        push_exp(8'h05, 8'h00);
        send_byte(8'h09);
        check("after_dato_a", 16'(dato_a), 16'h09);
        send_byte(8'h04);
        send_byte(8'h22);
        run_tx(1'b0, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        check("scoreboard_empty", 16'(exp_q.size()), 16'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
